// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared constants for the writeback port arbiter
//
// Holds the default geometry (requester count, data and register address
// widths), the requester index assignment and the reset value of the
// round-robin pointer.
package regfile_wb_arbiter_pkg;

    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;

    // Requester index assignment on in_req / in_dst / in_data.
    localparam int REQ_ALU  = 0;
    localparam int REQ_MEM  = 1;
    localparam int REQ_LINK = 2;

    // Width of an encoded requester index; never zero so a single requester
    // still has a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // last_gnt comes out of reset pointing at the highest index, so the
    // search starts at REQ_ALU.
    function automatic int last_gnt_rst(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request/grant bundle between sources and arbiter
//
// master : writeback sources (drive requests, receive grants and the staged write)
// slave  : the arbiter
//   in_hold   freeze, no grant while high
//   in_req    request per source
//   in_dst    destination register per source, source i at [i*AW +: AW]
//   in_data   write data per source, source i at [i*DW +: DW]
//   out_gnt   one-hot combinational grant
//   out_we    registered write enable
//   out_rw    registered write address
//   out_w     registered write data
//   out_pend  destinations requested or staged but not yet written
interface regfile_wb_arbiter_if #(
    parameter int NREQ = regfile_wb_arbiter_pkg::NREQ,
    parameter int DW   = regfile_wb_arbiter_pkg::DW,
    parameter int AW   = regfile_wb_arbiter_pkg::AW
);

    logic                 in_hold;
    logic [NREQ-1:0]      in_req;
    logic [NREQ*AW-1:0]   in_dst;
    logic [NREQ*DW-1:0]   in_data;
    logic [NREQ-1:0]      out_gnt;
    logic                 out_we;
    logic [AW-1:0]        out_rw;
    logic [DW-1:0]        out_w;
    logic [2**AW-1:0]     out_pend;

    modport master (
        output in_hold, in_req, in_dst, in_data,
        input  out_gnt, out_we, out_rw, out_w, out_pend
    );

    modport slave (
        input  in_hold, in_req, in_dst, in_data,
        output out_gnt, out_we, out_rw, out_w, out_pend
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// rtl/regfile_wb_arbiter_rr_pick.sv - combinational round-robin priority picker
//
// Ports:
//   req       request vector
//   last_gnt  index of the most recent grant
//   gnt       one-hot grant (all zero when nothing requests)
//   idx       encoded index of the granted requester
module regfile_wb_arbiter_rr_pick
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ = regfile_wb_arbiter_pkg::NREQ,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_gnt,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    // Walk the requesters starting one past last_gnt; the first asserted
    // request wins. last_gnt itself is visited last, so a lone requester
    // can still be granted back to back.
    always_comb begin
        logic found;
        int   cand;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = int'(last_gnt) + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter for the register file write port
//
// Shares the single register-file write port between the ALU, memory-load and
// link-address writeback sources. One grant per cycle; the granted command is
// staged into a register that drives the register file the following cycle.
//
// Ports:
//   in_clk    clock, rising edge
//   in_rst_n  asynchronous active-low reset
//   bus       regfile_wb_arbiter_if slave (requests, grant, staged write, pend map)
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ = regfile_wb_arbiter_pkg::NREQ,
    parameter int DW   = regfile_wb_arbiter_pkg::DW,
    parameter int AW   = regfile_wb_arbiter_pkg::AW
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    regfile_wb_arbiter_if.slave   bus
);

    localparam int IW = idx_width(NREQ);
    localparam logic [IW-1:0] LAST_RST = IW'(last_gnt_rst(NREQ));

    logic [IW-1:0]   last_gnt;
    logic [NREQ-1:0] req_eff;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [AW-1:0]   dst_sel;
    logic [DW-1:0]   data_sel;

    logic            stage_we;
    logic [AW-1:0]   stage_rw;
    logic [DW-1:0]   stage_w;
    logic [2**AW-1:0] pend;

    // Hold masks the requests seen by the picker, which freezes both the
    // grant and the pointer without touching the sources.
    assign req_eff = bus.in_hold ? '0 : bus.in_req;

    regfile_wb_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req      (req_eff),
        .last_gnt (last_gnt),
        .gnt      (gnt),
        .idx      (gnt_idx)
    );

    assign gnt_any = |gnt;

    // Grant is one-hot, so an OR-of-selected mux is sufficient.
    always_comb begin
        dst_sel  = '0;
        data_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                dst_sel  = dst_sel  | bus.in_dst[i*AW +: AW];
                data_sel = data_sel | bus.in_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            last_gnt <= LAST_RST;
            stage_we <= 1'b0;
            stage_rw <= '0;
            stage_w  <= '0;
        end else if (gnt_any) begin
            last_gnt <= gnt_idx;
            // Writes to register 0 are consumed but never reach the file.
            stage_we <= (dst_sel != '0);
            stage_rw <= dst_sel;
            stage_w  <= data_sel;
        end else begin
            stage_we <= 1'b0;
        end
    end

    // Pending map covers raw requests (held or not) plus the staged write;
    // register 0 is hardwired and never a hazard.
    always_comb begin
        pend = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.in_req[i]) begin
                pend[bus.in_dst[i*AW +: AW]] = 1'b1;
            end
        end
        if (stage_we) begin
            pend[stage_rw] = 1'b1;
        end
        pend[0] = 1'b0;
    end

    assign bus.out_gnt  = gnt;
    assign bus.out_we   = stage_we;
    assign bus.out_rw   = stage_rw;
    assign bus.out_w    = stage_w;
    assign bus.out_pend = pend;

endmodule
